instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Fetch/decode/execute controller for the 16-bit CPU. It holds the program counter and drives the instruction ROM address. It latches the returned 27-bit word and decodes it, then sequences the register file and ALU through one instruction at a time. It sits between the instruction ROM and the datapath (register file, ALU) and halts on an explicit HALT or on an invalid word.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset and on every start.
ALU_TIMEOUT, 16, max cycles to wait for alu_done before error-halt (>=1).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin execution from RESET_PC; honoured only in IDLE or HALT
rom_addr  out  16  instruction ROM address (= PC)
rom_data  in  27  instruction word, combinational from ROM
rf_raddr_a  out  2  register file read port A address
rf_raddr_b  out  2  register file read port B address
rf_waddr  out  2  register file write address
rf_we  out  1  register file write enable, one-cycle pulse
rf_wsel  out  1  write data select: 0 = imm, 1 = ALU result
imm  out  16  immediate field
alu_op  out  3  ALU operation (= opcode)
alu_opsel  out  1  ALU operand-select bit
alu_start  out  1  one-cycle ALU start pulse
alu_done  in  1  ALU result valid
busy  out  1  high in FETCH/DECODE/ALU_WAIT/WB
halted  out  1  high in HALT
err  out  1  set on ALU timeout; cleared by start
retired  out  16  count of completed instructions, saturates at 16'hFFFF

Behaviour:
- Instruction word fields:
  - [26:24] opcode
  - [23] opsel
  - [22:21] src_a
  - [20:19] src_b
  - [18:17] dst
  - [16:1] imm
  - [0] valid
- Opcodes:
  - 000 LOADI (dst <= imm)
  - 001 MOV (ALU pass A)
  - 010 ADD
  - 011 SUB
  - 100 MUL
  - 101 NAND
  - 110 XOR
  - 111 HALT
- Reset (async, rst_n low): state IDLE, PC = RESET_PC, instruction register = 0, all outputs 0 except rom_addr = RESET_PC.
- All decode outputs (raddr/waddr/imm/alu_op/alu_opsel) come from the registered instruction register. rf_we, alu_start, busy and halted are Moore outputs of the state.
- States:
  - IDLE: wait for start. On start, go to FETCH, set PC = RESET_PC, clear err and retired.
  - FETCH: rom_addr = PC; latch rom_data into the instruction register at the clock edge; go to DECODE.
  - DECODE:
    - valid == 0 or opcode == 111: go to HALT; PC is not advanced.
    - LOADI: go to WB with rf_wsel = 0.
    - Any other opcode: go to ALU_WAIT with rf_wsel = 1. alu_start is high during the DECODE cycle for ALU opcodes only.
  - ALU_WAIT: count cycles. alu_done is sampled from the first ALU_WAIT cycle onward.
    - alu_done: go to WB.
    - Counter reaches ALU_TIMEOUT without alu_done: set err and go to HALT, no write.
  - WB: rf_we = 1 for exactly this cycle; PC <= PC + 1 (wraps 16'hFFFF -> 16'h0000); retired++ (saturating); go to FETCH.
  - HALT: halted = 1; PC holds; start restarts exactly as from IDLE.
- Latency:
  - LOADI: 3 cycles, FETCH -> WB inclusive.
  - ALU op: 3 + N cycles, where N >= 1 is the ALU_WAIT length.
- start while busy is ignored. alu_done outside ALU_WAIT is ignored.
- Reset asserted mid-instruction aborts immediately: no rf_we, outputs go to reset values.
- ALU timeout counter is cleared on entry to ALU_WAIT.

Decomposition:
- Shared package cpu_isa_pkg holds:
  - INSTR_W = 27
  - field bit-position constants
  - opcode localparams/enum (OP_LOADI..OP_HALT)
  - sequencer state typedef
- Sub-module instr_decoder: combinational field extraction plus is_halt/is_alu/is_loadi flags from a 27-bit word.
- The FSM, PC, timeout counter and retired counter stay in instr_sequencer.

Test Plan:
1. ROM: 0x0000 = LOADI imm 0x000A dst 0; 0x0001 = LOADI imm 0x0005 dst 1; 0x0002 = HALT; pulse start -> rf_we pulses at cycles 3 and 6 with waddr 0/1, imm 0x000A/0x0005, rf_wsel = 0; halted = 1, retired = 2, rom_addr = 0x0002.
2. ADD (opcode 010, src_a 0, src_b 1, dst 2); ALU returns alu_done 2 cycles after alu_start -> alu_start is a single pulse with alu_op = 3'b010; rf_we with waddr 2 and rf_wsel = 1; instruction takes 5 cycles.
3. Word with valid = 0 at 0x0003 (default ROM data) -> HALT after DECODE, no rf_we, no alu_start, retired unchanged.
4. MUL with alu_done held low, ALU_TIMEOUT = 16 -> err = 1 and halted = 1 after 16 ALU_WAIT cycles, no write; a subsequent start clears err and rom_addr returns to 0x0000.
5. RESET_PC = 16'hFFFF with LOADI at 0xFFFF and HALT at 0x0000 -> PC wraps to 0x0000 and halts there, retired = 1.
6. rst_n dropped during ALU_WAIT and start pulsed while busy -> outputs reset asynchronously with no rf_we; start while busy produces no state change.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// ============================================================================
// Module   : cpu_isa_pkg
// Purpose  : Shared ISA definitions for the 16-bit CPU: instruction word
//            width, field bit positions, opcode encodings and the sequencer
//            state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_isa_pkg;

  localparam int INSTR_W = 27;

  // Instruction word field positions
  localparam int OPC_HI    = 26;
  localparam int OPC_LO    = 24;
  localparam int OPSEL_BIT = 23;
  localparam int SRCA_HI   = 22;
  localparam int SRCA_LO   = 21;
  localparam int SRCB_HI   = 20;
  localparam int SRCB_LO   = 19;
  localparam int DST_HI    = 18;
  localparam int DST_LO    = 17;
  localparam int IMM_HI    = 16;
  localparam int IMM_LO    = 1;
  localparam int VALID_BIT = 0;

  typedef enum logic [2:0] {
    OP_LOADI = 3'b000,
    OP_MOV   = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_MUL   = 3'b100,
    OP_NAND  = 3'b101,
    OP_XOR   = 3'b110,
    OP_HALT  = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_ALU_WAIT = 3'd3,
    ST_WB       = 3'd4,
    ST_HALT     = 3'd5
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_decoder.sv
// ============================================================================
// Module   : instr_decoder
// Purpose  : Combinational field extraction and instruction-class flags for
//            one 27-bit instruction word.
// Ports    : instr     in  27  instruction word
//            opcode    out 3   operation code
//            opsel     out 1   ALU operand-select bit
//            src_a     out 2   source register A
//            src_b     out 2   source register B
//            dst       out 2   destination register
//            imm       out 16  immediate field
//            is_halt   out 1   HALT opcode or invalid word
//            is_alu    out 1   valid ALU-class instruction
//            is_loadi  out 1   valid LOADI instruction
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_decoder
  import cpu_isa_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [2:0]         opcode,
  output logic               opsel,
  output logic [1:0]         src_a,
  output logic [1:0]         src_b,
  output logic [1:0]         dst,
  output logic [15:0]        imm,
  output logic               is_halt,
  output logic               is_alu,
  output logic               is_loadi
);

  logic valid;

  assign opcode = instr[OPC_HI:OPC_LO];
  assign opsel  = instr[OPSEL_BIT];
  assign src_a  = instr[SRCA_HI:SRCA_LO];
  assign src_b  = instr[SRCB_HI:SRCB_LO];
  assign dst    = instr[DST_HI:DST_LO];
  assign imm    = instr[IMM_HI:IMM_LO];
  assign valid  = instr[VALID_BIT];

  // An invalid word is treated exactly like HALT so the sequencer never
  // executes garbage fetched from an unprogrammed ROM location.
  assign is_halt  = !valid || (opcode == OP_HALT);
  assign is_loadi = valid && (opcode == OP_LOADI);
  assign is_alu   = valid && (opcode != OP_LOADI) && (opcode != OP_HALT);

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
// Module   : instr_sequencer
// Purpose  : Fetch/decode/execute controller. Holds the PC, latches the ROM
//            word into the instruction register and sequences the register
//            file and ALU one instruction at a time until HALT, an invalid
//            word, or an ALU timeout.
// Ports    : clk         in  1   system clock, rising edge
//            rst_n       in  1   asynchronous active-low reset
//            start       in  1   run from RESET_PC (IDLE/HALT only)
//            rom_addr    out 16  instruction ROM address (= PC)
//            rom_data    in  27  instruction word from ROM
//            rf_raddr_a  out 2   register file read address A
//            rf_raddr_b  out 2   register file read address B
//            rf_waddr    out 2   register file write address
//            rf_we       out 1   register file write enable (WB pulse)
//            rf_wsel     out 1   write data select: 0 imm, 1 ALU
//            imm         out 16  immediate field
//            alu_op      out 3   ALU operation
//            alu_opsel   out 1   ALU operand select
//            alu_start   out 1   ALU start pulse
//            alu_done    in  1   ALU result valid
//            busy        out 1   executing an instruction
//            halted      out 1   in HALT
//            err         out 1   ALU timeout occurred
//            retired     out 16  completed instruction count (saturating)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_sequencer
  import cpu_isa_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          ALU_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] rom_addr,
  input  logic [26:0] rom_data,
  output logic [1:0]  rf_raddr_a,
  output logic [1:0]  rf_raddr_b,
  output logic [1:0]  rf_waddr,
  output logic        rf_we,
  output logic        rf_wsel,
  output logic [15:0] imm,
  output logic [2:0]  alu_op,
  output logic        alu_opsel,
  output logic        alu_start,
  input  logic        alu_done,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [15:0] retired
);

  // Counter runs 0 .. ALU_TIMEOUT-1, one step per ALU_WAIT cycle.
  localparam int            TO_W    = (ALU_TIMEOUT < 2) ? 1 : $clog2(ALU_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ALU_TIMEOUT - 1);

  seq_state_e        state;
  seq_state_e        state_next;
  logic [15:0]       pc;
  logic [INSTR_W-1:0] ir;
  logic [TO_W-1:0]   to_cnt;
  logic [15:0]       retired_q;
  logic              err_q;

  logic              launch;
  logic              timeout_hit;

  logic [2:0]        dec_opcode;
  logic              dec_opsel;
  logic [1:0]        dec_src_a;
  logic [1:0]        dec_src_b;
  logic [1:0]        dec_dst;
  logic [15:0]       dec_imm;
  logic              dec_is_halt;
  logic              dec_is_alu;
  logic              dec_is_loadi;

  // Decode always works on the registered word so every decode output is
  // stable for the whole instruction, independent of ROM address changes.
  instr_decoder u_decoder (
    .instr    (ir),
    .opcode   (dec_opcode),
    .opsel    (dec_opsel),
    .src_a    (dec_src_a),
    .src_b    (dec_src_b),
    .dst      (dec_dst),
    .imm      (dec_imm),
    .is_halt  (dec_is_halt),
    .is_alu   (dec_is_alu),
    .is_loadi (dec_is_loadi)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and Moore outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    rf_we       = 1'b0;
    alu_start   = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    launch      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FETCH;
          launch     = 1'b1;
        end
      end
      ST_FETCH: begin
        busy       = 1'b1;
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        busy = 1'b1;
        if (dec_is_halt) begin
          state_next = ST_HALT;
        end else if (dec_is_loadi) begin
          state_next = ST_WB;
        end else begin
          state_next = ST_ALU_WAIT;
          alu_start  = 1'b1;
        end
      end
      ST_ALU_WAIT: begin
        busy = 1'b1;
        if (alu_done) begin
          state_next = ST_WB;
        end else if (to_cnt == TO_LAST) begin
          state_next  = ST_HALT;
          timeout_hit = 1'b1;
        end
      end
      ST_WB: begin
        busy       = 1'b1;
        rf_we      = 1'b1;
        state_next = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (start) begin
          state_next = ST_FETCH;
          launch     = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers: PC, instruction register, timeout and retire counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      ir        <= '0;
      to_cnt    <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (launch) begin
        pc        <= RESET_PC;
        err_q     <= 1'b0;
        retired_q <= '0;
      end
      if (state == ST_FETCH) begin
        ir <= rom_data;
      end
      // DECODE always precedes ALU_WAIT, so clearing here clears on entry.
      if (state == ST_DECODE) begin
        to_cnt <= '0;
      end else if (state == ST_ALU_WAIT) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
      if (state == ST_WB) begin
        pc <= pc + 16'd1;
        if (retired_q != 16'hFFFF) begin
          retired_q <= retired_q + 16'd1;
        end
      end
    end
  end

  assign rom_addr   = pc;
  assign rf_raddr_a = dec_src_a;
  assign rf_raddr_b = dec_src_b;
  assign rf_waddr   = dec_dst;
  assign rf_wsel    = dec_is_alu;
  assign imm        = dec_imm;
  assign alu_op     = dec_opcode;
  assign alu_opsel  = dec_opsel;
  assign err        = err_q;
  assign retired    = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// Module   : tb_instr_sequencer
// Purpose  : Self-checking bench for instr_sequencer. Stimulus pushes the
//            expected register-file writes and ALU starts into queues; a
//            monitor pops and compares whenever the DUT pulses rf_we or
//            alu_start. A second instance covers RESET_PC = 16'hFFFF.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_sequencer;
  import cpu_isa_pkg::*;

  typedef struct {
    logic [1:0]  waddr;
    logic        wsel;
    logic [15:0] imm;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [2:0] op;
    logic       opsel;
    logic [1:0] ra;
    logic [1:0] rb;
    int         cyc;
  } alu_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic alu_done = 1'b0;
  logic alu_done2 = 1'b0;

  logic [15:0] rom_addr, rom_addr2;
  logic [26:0] rom_data, rom_data2;
  logic [1:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [1:0]  rf_raddr_a2, rf_raddr_b2, rf_waddr2;
  logic        rf_we, rf_wsel, rf_we2, rf_wsel2;
  logic [15:0] imm, imm2;
  logic [2:0]  alu_op, alu_op2;
  logic        alu_opsel, alu_opsel2, alu_start, alu_start2;
  logic        busy, halted, err, busy2, halted2, err2;
  logic [15:0] retired, retired2;

  logic [26:0] rom [0:7];
  logic [26:0] rom2_ff;
  logic [26:0] rom2_00;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int base  = 0;
  bit alu_en = 1'b0;
  int alu_cnt = 0;

  wr_t  exp_wr[$];
  wr_t  exp_wr2[$];
  alu_t exp_alu[$];
  wr_t  ew;
  wr_t  ew2;
  alu_t ea;

  assign rom_data  = (rom_addr < 16'd8) ? rom[rom_addr[2:0]] : 27'd0;
  assign rom_data2 = (rom_addr2 == 16'hFFFF) ? rom2_ff :
                     (rom_addr2 == 16'h0000) ? rom2_00 : 27'd0;

  instr_sequencer #(.RESET_PC(16'h0000), .ALU_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .imm(imm),
    .alu_op(alu_op), .alu_opsel(alu_opsel), .alu_start(alu_start),
    .alu_done(alu_done), .busy(busy), .halted(halted), .err(err),
    .retired(retired)
  );

  instr_sequencer #(.RESET_PC(16'hFFFF), .ALU_TIMEOUT(16)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .rom_addr(rom_addr2), .rom_data(rom_data2),
    .rf_raddr_a(rf_raddr_a2), .rf_raddr_b(rf_raddr_b2), .rf_waddr(rf_waddr2),
    .rf_we(rf_we2), .rf_wsel(rf_wsel2), .imm(imm2),
    .alu_op(alu_op2), .alu_opsel(alu_opsel2), .alu_start(alu_start2),
    .alu_done(alu_done2), .busy(busy2), .halted(halted2), .err(err2),
    .retired(retired2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [26:0] mk(input logic [2:0] op, input logic opsel,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] d, input logic [15:0] iv,
                                     input logic v);
    return {op, opsel, a, b, d, iv, v};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ALU model: alu_done is high during the second ALU_WAIT cycle.
  always @(negedge clk) begin
    alu_done = 1'b0;
    if (alu_cnt > 0) begin
      alu_cnt = alu_cnt - 1;
      if (alu_cnt == 0) alu_done = 1'b1;
    end
    if (alu_start && alu_en) alu_cnt = 2;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rf_we) begin
      if (exp_wr.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wr_unexpected: waddr=%0d imm=0x%0h at cycle %0d, expected no write",
                 rf_waddr, imm, cyc - base + 1);
      end else begin
        ew = exp_wr.pop_front();
        chk("wr_waddr", 32'(rf_waddr), 32'(ew.waddr));
        chk("wr_wsel",  32'(rf_wsel),  32'(ew.wsel));
        chk("wr_imm",   32'(imm),      32'(ew.imm));
        chk("wr_cycle", 32'(cyc - base + 1), 32'(ew.cyc));
      end
    end
    if (alu_start) begin
      if (exp_alu.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL alu_unexpected: alu_op=%0d at cycle %0d, expected no alu_start",
                 alu_op, cyc - base + 1);
      end else begin
        ea = exp_alu.pop_front();
        chk("alu_op",    32'(alu_op),     32'(ea.op));
        chk("alu_opsel", 32'(alu_opsel),  32'(ea.opsel));
        chk("alu_ra",    32'(rf_raddr_a), 32'(ea.ra));
        chk("alu_rb",    32'(rf_raddr_b), 32'(ea.rb));
        chk("alu_cycle", 32'(cyc - base + 1), 32'(ea.cyc));
      end
    end
    if (rf_we2) begin
      if (exp_wr2.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wr2_unexpected: waddr=%0d imm=0x%0h, expected no write", rf_waddr2, imm2);
      end else begin
        ew2 = exp_wr2.pop_front();
        chk("wr2_waddr", 32'(rf_waddr2), 32'(ew2.waddr));
        chk("wr2_wsel",  32'(rf_wsel2),  32'(ew2.wsel));
        chk("wr2_imm",   32'(imm2),      32'(ew2.imm));
        chk("wr2_cycle", 32'(cyc - base + 1), 32'(ew2.cyc));
      end
    end
    if (alu_start2) begin
      n_cmp++; n_bad++;
      $display("FAIL alu2_unexpected: alu_op=%0d, expected no alu_start", alu_op2);
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 8; i++) rom[i] = 27'd0;
  endtask

  // Start is taken at the posedge; the following negedge is cycle 1 (FETCH).
  task automatic pulse_start(input int which);
    @(negedge clk);
    if (which == 0) start = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
    base   = cyc;
  endtask

  task automatic wait_halt(input int which, input int exp_rel);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((which == 0) ? halted : halted2) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL halt_timeout: halted never rose, expected at cycle %0d", exp_rel);
    end else begin
      chk("halt_cycle", 32'(cyc - base + 1), 32'(exp_rel));
    end
  endtask

  task automatic chk_queues();
    chk("wr_queue_left",  32'(exp_wr.size()),  32'd0);
    chk("alu_queue_left", 32'(exp_alu.size()), 32'd0);
    chk("wr2_queue_left", 32'(exp_wr2.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_rom();
    rom2_ff = mk(OP_LOADI, 1'b0, 2'd0, 2'd0, 2'd3, 16'h1234, 1'b1);
    rom2_00 = mk(OP_HALT,  1'b0, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b1);

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rom_addr",  32'(rom_addr),  32'h0000);
    chk("rst_rom_addr2", 32'(rom_addr2), 32'hFFFF);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_halted",    32'(halted),    32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_retired",   32'(retired),   32'd0);
    chk("rst_imm",       32'(imm),       32'd0);
    chk("rst_alu_op",    32'(alu_op),    32'd0);

    // Two LOADIs then HALT
    rom[0] = mk(OP_LOADI, 1'b0, 2'd0, 2'd0, 2'd0, 16'h000A, 1'b1);
    rom[1] = mk(OP_LOADI, 1'b0, 2'd0, 2'd0, 2'd1, 16'h0005, 1'b1);
    rom[2] = mk(OP_HALT,  1'b0, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b1);
    exp_wr.push_back('{2'd0, 1'b0, 16'h000A, 3});
    exp_wr.push_back('{2'd1, 1'b0, 16'h0005, 6});
    pulse_start(0);
    wait_halt(0, 9);
    chk("t1_retired",  32'(retired),  32'd2);
    chk("t1_rom_addr", 32'(rom_addr), 32'h0002);
    chk("t1_busy",     32'(busy),     32'd0);
    chk("t1_err",      32'(err),      32'd0);
    chk_queues();

    // ADD with 2-cycle ALU latency
    clear_rom();
    rom[0] = mk(OP_ADD,  1'b0, 2'd0, 2'd1, 2'd2, 16'h0000, 1'b1);
    rom[1] = mk(OP_HALT, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b1);
    alu_en = 1'b1;
    exp_alu.push_back('{3'b010, 1'b0, 2'd0, 2'd1, 2});
    exp_wr.push_back('{2'd2, 1'b1, 16'h0000, 5});
    pulse_start(0);
    wait_halt(0, 8);
    chk("t2_retired",  32'(retired),  32'd1);
    chk("t2_rom_addr", 32'(rom_addr), 32'h0001);
    chk_queues();

    // Invalid word at 0x0003 after three LOADIs
    clear_rom();
    rom[0] = mk(OP_LOADI, 1'b0, 2'd0, 2'd0, 2'd3, 16'h0007, 1'b1);
    rom[1] = mk(OP_LOADI, 1'b0, 2'd0, 2'd0, 2'd2, 16'hFFFF, 1'b1);
    rom[2] = mk(OP_LOADI, 1'b0, 2'd0, 2'd0, 2'd0, 16'h8001, 1'b1);
    exp_wr.push_back('{2'd3, 1'b0, 16'h0007, 3});
    exp_wr.push_back('{2'd2, 1'b0, 16'hFFFF, 6});
    exp_wr.push_back('{2'd0, 1'b0, 16'h8001, 9});
    pulse_start(0);
    wait_halt(0, 12);
    chk("t3_retired",  32'(retired),  32'd3);
    chk("t3_rom_addr", 32'(rom_addr), 32'h0003);
    chk_queues();

    // MUL with no alu_done: timeout after 16 ALU_WAIT cycles
    clear_rom();
    rom[0] = mk(OP_MUL, 1'b1, 2'd2, 2'd3, 2'd1, 16'h0000, 1'b1);
    alu_en = 1'b0;
    exp_alu.push_back('{3'b100, 1'b1, 2'd2, 2'd3, 2});
    pulse_start(0);
    wait_halt(0, 19);
    chk("t4_err",      32'(err),      32'd1);
    chk("t4_retired",  32'(retired),  32'd0);
    chk("t4_rom_addr", 32'(rom_addr), 32'h0000);
    chk_queues();
    rom[0] = mk(OP_HALT, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b1);
    pulse_start(0);
    chk("t4_restart_err",  32'(err),      32'd0);
    chk("t4_restart_busy", 32'(busy),     32'd1);
    chk("t4_restart_addr", 32'(rom_addr), 32'h0000);
    wait_halt(0, 3);
    chk("t4_restart_err2", 32'(err), 32'd0);
    chk_queues();

    // Start pulsed during ALU_WAIT must be ignored
    clear_rom();
    rom[0] = mk(OP_ADD,  1'b0, 2'd0, 2'd1, 2'd2, 16'h0000, 1'b1);
    rom[1] = mk(OP_HALT, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0000, 1'b1);
    alu_en = 1'b1;
    exp_alu.push_back('{3'b010, 1'b0, 2'd0, 2'd1, 2});
    exp_wr.push_back('{2'd2, 1'b1, 16'h0000, 5});
    pulse_start(0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_halt(0, 8);
    chk("t6_retired", 32'(retired), 32'd1);
    chk_queues();

    // Asynchronous reset in the middle of ALU_WAIT
    alu_en = 1'b0;
    exp_alu.push_back('{3'b010, 1'b0, 2'd0, 2'd1, 2});
    pulse_start(0);
    repeat (4) @(negedge clk);
    chk("t6_in_wait_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_rom_addr", 32'(rom_addr),  32'h0000);
    chk("t6_rst_busy",     32'(busy),      32'd0);
    chk("t6_rst_halted",   32'(halted),    32'd0);
    chk("t6_rst_rf_we",    32'(rf_we),     32'd0);
    chk("t6_rst_waddr",    32'(rf_waddr),  32'd0);
    chk("t6_rst_alu_op",   32'(alu_op),    32'd0);
    chk("t6_rst_wsel",     32'(rf_wsel),   32'd0);
    chk("t6_rst_retired",  32'(retired),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_idle_busy",   32'(busy),   32'd0);
    chk("t6_idle_halted", 32'(halted), 32'd0);
    chk_queues();

    // RESET_PC = 16'hFFFF: PC wraps to 0x0000 and halts there
    exp_wr2.push_back('{2'd3, 1'b0, 16'h1234, 3});
    pulse_start(1);
    wait_halt(1, 6);
    chk("t5_rom_addr", 32'(rom_addr2), 32'h0000);
    chk("t5_retired",  32'(retired2),  32'd1);
    chk("t5_err",      32'(err2),      32'd0);
    chk_queues();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
